// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU memory stage, image-load DMA),
// the shared data-RAM arbiter and the single-port RAM macro.
//   slave  : arbiter view (takes requests and RAM read data, drives grants,
//            read returns and the RAM control).
//   master : requester/RAM view (the mirror of slave).
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 17
);
  // CPU side
  logic              cpu_req;
  logic              cpu_we;
  logic [23:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  // DMA side
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  // RAM side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_addr;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output err_addr
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  err_addr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port data RAM shared by the CPU memory stage and the
// image-load DMA. One access is granted per cycle; the CPU has priority, but a
// DMA denied MAX_WAIT cycles in a row is forced through. Out-of-range accesses
// are granted (so the pipeline stall always resolves) but never reach the RAM;
// they pulse err_addr the following cycle and reads return 0.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (requests, grants, read returns, RAM)
module mem_port_arbiter #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DEPTH    = 90000,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  // Read-return tag: valid, owner (1 = DMA), out-of-range.
  logic              tag_valid_q, tag_owner_q, tag_oor_q;
  logic              err_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  logic              cpu_oor, dma_oor;
  logic              cpu_gnt, dma_gnt, any_gnt;
  logic              gnt_we, gnt_oor;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [DATA_W-1:0] ret_data;
  logic              cpu_rvalid, dma_rvalid;

  // Upper cpu_addr bits above ADDR_W fall out naturally from the full compare.
  assign cpu_oor = 32'(bus.cpu_addr) >= DEPTH;
  assign dma_oor = 32'(bus.dma_addr) >= DEPTH;

  always_comb begin
    // Grants are forced low while reset is held.
    dma_gnt = rst_ni & bus.dma_req &
              (~bus.cpu_req | (wait_cnt_q == WaitW'(MAX_WAIT)));
    cpu_gnt = rst_ni & bus.cpu_req & ~dma_gnt;
    any_gnt = cpu_gnt | dma_gnt;

    gnt_we    = 1'b0;
    gnt_oor   = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    if (cpu_gnt) begin
      gnt_we    = bus.cpu_we;
      gnt_oor   = cpu_oor;
      gnt_addr  = bus.cpu_addr[ADDR_W-1:0];
      gnt_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      gnt_we    = bus.dma_we;
      gnt_oor   = dma_oor;
      gnt_addr  = bus.dma_addr;
      gnt_wdata = bus.dma_wdata;
    end

    if (bus.dma_req && !dma_gnt) begin
      wait_cnt_d = (wait_cnt_q == WaitW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = '0;
    end

    ret_data   = tag_oor_q ? '0 : bus.mem_rdata;
    cpu_rvalid = tag_valid_q & ~tag_owner_q;
    dma_rvalid = tag_valid_q & tag_owner_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q  <= '0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
      tag_oor_q   <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      tag_valid_q <= any_gnt & ~gnt_we;
      tag_owner_q <= dma_gnt;
      tag_oor_q   <= gnt_oor;
      err_q       <= any_gnt & gnt_oor;
      if (cpu_rvalid) cpu_rdata_q <= ret_data;
      if (dma_rvalid) dma_rdata_q <= ret_data;
    end
  end

  // RAM read data only exists in the return cycle, so rdata bypasses the
  // holding register while rvalid is high and shows the held value otherwise.
  assign bus.cpu_rdata  = cpu_rvalid ? ret_data : cpu_rdata_q;
  assign bus.dma_rdata  = dma_rvalid ? ret_data : dma_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.mem_en     = any_gnt & ~gnt_oor;
  assign bus.mem_we     = gnt_we & any_gnt & ~gnt_oor;
  assign bus.mem_addr   = gnt_addr;
  assign bus.mem_wdata  = gnt_wdata;
  assign bus.err_addr   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural RAM sits on the mem_*
// side; inputs change 1 time unit after the rising edge and outputs are
// checked 2 units later, mid-cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.DATA_W(24), .ADDR_W(17)) bus ();

  mem_port_arbiter #(
    .DATA_W  (24),
    .ADDR_W  (17),
    .DEPTH   (90000),
    .MAX_WAIT(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  logic [23:0] ram [0:131071];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic cpu(input logic we, input logic [23:0] a, input logic [23:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma(input logic we, input logic [16:0] a, input logic [23:0] d);
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.mem_rdata = '0;
    ram[1]     = 24'hABCDEF;
    ram[2]     = 24'h000000;
    ram[89999] = 24'h55AA55;
    ram[90001] = 24'h000000;
    idle();
    rst_n = 1'b0;

    // Reset held with a CPU request present: nothing granted.
    #1;
    cpu(1'b0, 24'h000001, '0);
    #2;
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_err", 32'(bus.err_addr), 0);
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // CPU read of RAM[1].
    cpu(1'b0, 24'h000001, '0);
    #2;
    chk("rd1_cpu_gnt", 32'(bus.cpu_gnt), 1);
    chk("rd1_mem_addr", 32'(bus.mem_addr), 1);
    chk("rd1_mem_en", 32'(bus.mem_en), 1);
    chk("rd1_stall", 32'(bus.cpu_stall), 0);
    tick();
    idle();
    #2;
    chk("rd1_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("rd1_rdata", 32'(bus.cpu_rdata), 32'hABCDEF);
    chk("rd1_dma_rvalid", 32'(bus.dma_rvalid), 0);
    tick();
    #2;
    chk("rd1_rvalid_drop", 32'(bus.cpu_rvalid), 0);
    chk("rd1_rdata_held", 32'(bus.cpu_rdata), 32'hABCDEF);

    // DMA write to addr 2, then CPU read back.
    tick();
    dma(1'b1, 17'd2, 24'h123456);
    #2;
    chk("dwr_dma_gnt", 32'(bus.dma_gnt), 1);
    chk("dwr_mem_we", 32'(bus.mem_we), 1);
    chk("dwr_mem_wdata", 32'(bus.mem_wdata), 32'h123456);
    tick();
    idle();
    cpu(1'b0, 24'h000002, '0);
    #2;
    chk("dwr_no_rvalid", 32'(bus.dma_rvalid), 0);
    chk("crd2_gnt", 32'(bus.cpu_gnt), 1);
    tick();
    idle();
    #2;
    chk("crd2_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("crd2_rdata", 32'(bus.cpu_rdata), 32'h123456);
    tick();

    // Contention: both requesters for 12 cycles; DMA forced in cycles 5 and 10.
    cpu(1'b0, 24'h000001, '0);
    dma(1'b0, 17'd2, '0);
    for (int c = 1; c <= 12; c++) begin
      #2;
      chk($sformatf("cont_dma_gnt_c%0d", c), 32'(bus.dma_gnt), 32'((c == 5) || (c == 10)));
      chk($sformatf("cont_stall_c%0d", c), 32'(bus.cpu_stall), 32'((c == 5) || (c == 10)));
      chk($sformatf("cont_cpu_gnt_c%0d", c), 32'(bus.cpu_gnt), 32'((c != 5) && (c != 10)));
      tick();
    end
    idle();
    #2;
    chk("cont_idle_stall", 32'(bus.cpu_stall), 0);
    tick();

    // Boundary: last valid word.
    cpu(1'b0, 24'd89999, '0);
    #2;
    chk("b0_mem_en", 32'(bus.mem_en), 1);
    tick();
    idle();
    #2;
    chk("b0_rdata", 32'(bus.cpu_rdata), 32'h55AA55);
    chk("b0_err", 32'(bus.err_addr), 0);
    tick();

    // First out-of-range word.
    cpu(1'b0, 24'd90000, '0);
    #2;
    chk("b1_gnt", 32'(bus.cpu_gnt), 1);
    chk("b1_mem_en", 32'(bus.mem_en), 0);
    tick();
    idle();
    #2;
    chk("b1_err", 32'(bus.err_addr), 1);
    chk("b1_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("b1_rdata", 32'(bus.cpu_rdata), 0);
    tick();
    #2;
    chk("b1_err_pulse", 32'(bus.err_addr), 0);

    // Address above ADDR_W bits (low 17 bits are 0).
    cpu(1'b0, 24'h020000, '0);
    #2;
    chk("b2_mem_en", 32'(bus.mem_en), 0);
    tick();
    idle();
    #2;
    chk("b2_err", 32'(bus.err_addr), 1);
    chk("b2_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("b2_rdata", 32'(bus.cpu_rdata), 0);
    tick();

    // Out-of-range write is dropped.
    cpu(1'b1, 24'd90001, 24'h777777);
    #2;
    chk("b3_mem_we", 32'(bus.mem_we), 0);
    chk("b3_mem_en", 32'(bus.mem_en), 0);
    tick();
    idle();
    #2;
    chk("b3_err", 32'(bus.err_addr), 1);
    chk("b3_no_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("b3_ram_kept", 32'(ram[90001]), 0);
    tick();

    // Alternating reads: CPU, DMA, CPU.
    cpu(1'b0, 24'h000001, '0);
    #2;
    chk("alt1_cpu_gnt", 32'(bus.cpu_gnt), 1);
    tick();
    idle();
    dma(1'b0, 17'd89999, '0);
    #2;
    chk("alt2_dma_gnt", 32'(bus.dma_gnt), 1);
    chk("alt1_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("alt1_cpu_rdata", 32'(bus.cpu_rdata), 32'hABCDEF);
    chk("alt1_dma_rdata_held", 32'(bus.dma_rdata), 32'h123456);
    tick();
    idle();
    cpu(1'b0, 24'h000002, '0);
    #2;
    chk("alt3_cpu_gnt", 32'(bus.cpu_gnt), 1);
    chk("alt2_dma_rvalid", 32'(bus.dma_rvalid), 1);
    chk("alt2_dma_rdata", 32'(bus.dma_rdata), 32'h55AA55);
    chk("alt2_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("alt2_cpu_rdata_held", 32'(bus.cpu_rdata), 32'hABCDEF);
    tick();
    idle();
    #2;
    chk("alt3_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("alt3_cpu_rdata", 32'(bus.cpu_rdata), 32'h123456);
    chk("alt3_dma_rdata_held", 32'(bus.dma_rdata), 32'h55AA55);
    tick();

    // Reset while a read return is pending.
    cpu(1'b0, 24'h000001, '0);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mrst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("mrst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("mrst_dma_rdata", 32'(bus.dma_rdata), 0);
    chk("mrst_err", 32'(bus.err_addr), 0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("mrst_after_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("mrst_after_dma_rvalid", 32'(bus.dma_rvalid), 0);
    tick();
    #2;
    chk("mrst_after2_cpu_rvalid", 32'(bus.cpu_rvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
